// File: rtl/des_pkg.sv
// Shared widths, arbiter state encoding and round-robin helper for the DES
// core arbiter and its sub-blocks.
package des_pkg;

    localparam int DES_BLOCK_W = 64;
    localparam int DES_RKEY_W  = 48;
    localparam int DES_KEYS_W  = 16 * DES_RKEY_W;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } des_arb_state_t;

    // Pointer value that follows a grant to idx, wrapping at n requesters.
    function automatic int des_rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/des_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after the
// pointer, searching cyclically. Returns one-hot grant, its index and found.
module des_rr_picker
    import des_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req_valid,
    input  logic [IDX_W-1:0] i_rr_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_found
);

    logic [IDX_W-1:0] w_pos;
    logic             w_hit;

    // Walk requesters from the pointer onward; the first hit masks all later ones.
    always_comb begin
        o_grant     = {N_REQ{1'b0}};
        o_grant_idx = {IDX_W{1'b0}};
        o_found     = 1'b0;
        w_pos       = {IDX_W{1'b0}};
        w_hit       = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            w_pos          = IDX_W'((int'(i_rr_ptr) + k) % N_REQ);
            w_hit          = i_req_valid[w_pos] & ~o_found;
            o_grant[w_pos] = o_grant[w_pos] | w_hit;
            o_grant_idx    = w_hit ? w_pos : o_grant_idx;
            o_found        = o_found | w_hit;
        end
    end

endmodule

// File: rtl/des_core_arbiter.sv
// Round-robin scheduler sharing one DES core between N_REQ requesters.
// Optional watchdog on the core is enabled by defining DES_ARB_TIMEOUT_EN.
module des_core_arbiter
    import des_pkg::*;
#(
    parameter  int N_REQ          = 4,
    parameter  int TIMEOUT_CYCLES = 64,
    localparam int IDX_W          = $clog2(N_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*DES_BLOCK_W-1:0]  req_message,
    input  logic [N_REQ*DES_KEYS_W-1:0]   req_keys,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [IDX_W-1:0]              rsp_id,
    output logic [DES_BLOCK_W-1:0]        rsp_result,
    output logic                          rsp_err,
    output logic                          core_start,
    output logic [DES_BLOCK_W-1:0]        core_message,
    output logic [DES_KEYS_W-1:0]         core_keys,
    input  logic                          core_done,
    input  logic [DES_BLOCK_W-1:0]        core_result,
    output logic                          core_rst_n
);

    des_arb_state_t          r_state;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic                    r_rsp_valid;
    logic [IDX_W-1:0]        r_rsp_id;
    logic [DES_BLOCK_W-1:0]  r_rsp_result;
    logic                    r_core_start;
    logic [DES_BLOCK_W-1:0]  r_core_message;
    logic [DES_KEYS_W-1:0]   r_core_keys;

    logic [N_REQ-1:0]        w_grant;
    logic [IDX_W-1:0]        w_grant_idx;
    logic                    w_found;
    logic [DES_BLOCK_W-1:0]  w_sel_msg;
    logic [DES_KEYS_W-1:0]   w_sel_keys;

`ifdef DES_ARB_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDOG_W-1:0]       r_wdog;
    logic                    r_rsp_err;
    logic                    r_core_abort;
`endif

    des_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .i_req_valid (req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_found     (w_found)
    );

    // One-hot AND-OR select of the granted requester's message and keys.
    always_comb begin
        w_sel_msg  = {DES_BLOCK_W{1'b0}};
        w_sel_keys = {DES_KEYS_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            w_sel_msg  = w_sel_msg  | (req_message[i*DES_BLOCK_W +: DES_BLOCK_W] & {DES_BLOCK_W{w_grant[i]}});
            w_sel_keys = w_sel_keys | (req_keys[i*DES_KEYS_W +: DES_KEYS_W] & {DES_KEYS_W{w_grant[i]}});
        end
    end

    // Accept is offered only in IDLE and never while reset is held.
    assign req_ready = (r_state == ARB_IDLE && rst_n) ? w_grant : {N_REQ{1'b0}};

    // Arbiter FSM: accept, pulse start, wait for the core, hold the response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ARB_IDLE;
            r_rr_ptr       <= {IDX_W{1'b0}};
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= {IDX_W{1'b0}};
            r_rsp_result   <= {DES_BLOCK_W{1'b0}};
            r_core_start   <= 1'b0;
            r_core_message <= {DES_BLOCK_W{1'b0}};
            r_core_keys    <= {DES_KEYS_W{1'b0}};
`ifdef DES_ARB_TIMEOUT_EN
            r_wdog         <= {WDOG_W{1'b0}};
            r_rsp_err      <= 1'b0;
            r_core_abort   <= 1'b0;
`endif
        end else begin
            r_core_start <= 1'b0;
`ifdef DES_ARB_TIMEOUT_EN
            r_core_abort <= 1'b0;
`endif
            case (r_state)
                ARB_IDLE: begin
                    if (w_found) begin
                        r_core_message <= w_sel_msg;
                        r_core_keys    <= w_sel_keys;
                        r_rsp_id       <= w_grant_idx;
                        r_rr_ptr       <= IDX_W'(des_rr_next(int'(w_grant_idx), N_REQ));
                        r_core_start   <= 1'b1;
                        r_state        <= ARB_ISSUE;
`ifdef DES_ARB_TIMEOUT_EN
                        r_wdog         <= {WDOG_W{1'b0}};
`endif
                    end else begin
                        r_state <= ARB_IDLE;
                    end
                end
                ARB_ISSUE: begin
                    r_state <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (core_done) begin
                        r_rsp_result <= core_result;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= ARB_RESP;
`ifdef DES_ARB_TIMEOUT_EN
                        r_rsp_err    <= 1'b0;
                    end else if (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                        r_rsp_result <= {DES_BLOCK_W{1'b0}};
                        r_rsp_err    <= 1'b1;
                        r_rsp_valid  <= 1'b1;
                        r_core_abort <= 1'b1;
                        r_state      <= ARB_RESP;
                    end else begin
                        r_wdog <= r_wdog + WDOG_W'(1);
                    end
`else
                    end else begin
                        r_state <= ARB_WAIT;
                    end
`endif
                end
                ARB_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ARB_IDLE;
                    end else begin
                        r_state <= ARB_RESP;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_result   = r_rsp_result;
    assign core_start   = r_core_start;
    assign core_message = r_core_message;
    assign core_keys    = r_core_keys;

`ifdef DES_ARB_TIMEOUT_EN
    assign rsp_err    = r_rsp_err;
    assign core_rst_n = rst_n & ~r_core_abort;
`else
    assign rsp_err    = 1'b0;
    assign core_rst_n = rst_n;
`endif

endmodule

// File: doc/des_core_arbiter.md
# des_core_arbiter

Round-robin scheduler that shares one `des_encryption_unroll8` core between `N_REQ` requesters. It accepts a request through a valid/ready handshake and registers the message and round keys. It then pulses the core's `start`, captures the result on the core's `done`, and returns the result on a single valid/ready response channel tagged with the requester index. It sits between the host-side request ports and the encryption core.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 64: watchdog limit in cycles. Used only when `DES_ARB_TIMEOUT_EN` is defined.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in N_REQ: per-requester request valid.
- `req_ready` out N_REQ: per-requester accept. At most one bit is high.
- `req_message` in N_REQ*64: plaintext. Requester i uses bits [i*64 +: 64].
- `req_keys` in N_REQ*768: 16×48 round keys. Requester i uses bits [i*768 +: 768].
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accept.
- `rsp_id` out $clog2(N_REQ): index of the requester that issued the request.
- `rsp_result` out 64: ciphertext.
- `rsp_err` out 1: timeout flag. Tied 0 when the macro is off.
- `core_start` out 1: start pulse to the core.
- `core_message` out 64: message to the core, from the data register.
- `core_keys` out 768: round keys to the core, from the data register.
- `core_done` in 1: done from the core.
- `core_result` in 64: result from the core.
- `core_rst_n` out 1: reset to the core.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant goes to the first `req_valid` bit at or after `rr_ptr`, searching cyclically.
  - `req_ready[grant]` is asserted combinationally.
  - On handshake, register `req_message[grant]`, `req_keys[grant]` and the grant index, set `rr_ptr <= (grant+1) mod N_REQ`, and go to ISSUE.
  - If no `req_valid` bit is set, stay in IDLE and leave `rr_ptr` unchanged.
- ISSUE: `core_start=1` for exactly one cycle, then go to WAIT.
- WAIT:
  - On `core_done`, capture `core_result` into `rsp_result` with `rsp_err=0`, then go to RESP.
  - `core_done` is sampled in WAIT only. A `core_done` in any other state is ignored.
- RESP:
  - `rsp_valid=1`. `rsp_id`, `rsp_result` and `rsp_err` are held stable.
  - On `rsp_ready`, go to IDLE.
- `req_ready` is never asserted outside IDLE. A new request is always at least one cycle after response acceptance.
- A start issued in the core's finished state would be lost. The minimum gap of 2 cycles from `core_done` to the next `core_start` guarantees the core is back in init.
- `core_message` and `core_keys` stay stable from ISSUE until the next accept.

## Timing
- Reset values:
  - `state=IDLE`, `rr_ptr=0`.
  - All outputs are 0: `req_ready`, `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_err`, `core_start`, `core_message`, `core_keys`.
  - Exception: `core_rst_n` follows `rst_n`.
- Request accepted at cycle T:
  - `core_start` at T+1.
  - `core_done` at cycle D.
  - `rsp_valid` at D+1.
- Arbiter overhead is 2 cycles plus core latency.
- Response back-pressure: `rsp_valid` holds indefinitely until `rsp_ready`.
- Reset mid-operation: the in-flight request is dropped and no response is produced. The core is reset by the same `rst_n` through `core_rst_n`.
- Fairness: with all requesters valid continuously, grants rotate 0,1,…,N_REQ-1,0.

## Configuration
- `DES_ARB_TIMEOUT_EN` defined:
  - A watchdog counts cycles in WAIT.
  - When it reaches `TIMEOUT_CYCLES` without `core_done`:
    - Go to RESP with `rsp_err=1` and `rsp_result=0`.
    - Drive `core_rst_n=0` for exactly one cycle, which aborts the core.
  - The watchdog clears on entry to ISSUE.
- `DES_ARB_TIMEOUT_EN` undefined:
  - No watchdog; WAIT lasts until `core_done`.
  - `rsp_err` is tied 0 and `core_rst_n = rst_n`.

## Structure
- Shared package `des_pkg`:
  - `DES_BLOCK_W=64`, `DES_KEYS_W=768`, `DES_RKEY_W=48`.
  - Arbiter state enum `des_arb_state_t`.
- Sub-module `des_rr_picker`: combinational round-robin grant from `req_valid` and `rr_ptr`. Outputs a one-hot grant, the encoded index, and a `found` flag.

## Test plan
- Single request: requester 2 sends message 0x0123456789ABCDEF with round keys for key 0x133457799BBCDFF1 -> exactly one `core_start` pulse, then `rsp_id=2`, `rsp_result=0x85E813540F0AB405`, `rsp_err=0`.
- Fairness: all 4 `req_valid` held high for 8 transactions -> `rsp_id` sequence 0,1,2,3,0,1,2,3.
- Back-pressure: `rsp_ready` held low for 20 cycles -> `rsp_valid` and `rsp_result` stable throughout, `req_ready=0`, and no second `core_start`.
- Reset mid-operation: `rst_n=0` during WAIT -> next cycle `state=IDLE`, all outputs 0, `rr_ptr=0`, and no response.
- Spurious done: a `core_done` pulse while in IDLE -> no `rsp_valid`.
- Timeout (macro on, `TIMEOUT_CYCLES=16`): core model never asserts done -> `rsp_valid` with `rsp_err=1`, `rsp_result=0`, and a one-cycle `core_rst_n` low pulse. A following request then completes normally.
